// File: rtl/i2c_target_if.sv
`timescale 1ns/1ps
// i2c_target_if: I2C pin levels plus the register-port strobes of the I2C target.
// The slave modport is the target's view; master is the controller/register-file side.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: oversampling I2C responder that maps bus transfers onto an 8-bit register port.
// Define I2C_TARGET_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizers.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_p_q, sda_p_q;
  logic                   start_c, stop_c, scl_rise, scl_fall;

  // Synchronizers idle high so reset release never looks like a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end

  // START/STOP need SCL high on both samples, so they never coincide with an SCL edge.
  assign start_c  = scl_s & scl_p_q &  sda_p_q & ~sda_s;
  assign stop_c   = scl_s & scl_p_q & ~sda_p_q &  sda_s;
  assign scl_rise =  scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s &  scl_p_q;

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {rx_q, sda_s};
  assign last_bit = (bitcnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;

    // Read data arrives the cycle after the strobe; write pointer bumps the cycle after reg_we.
    if (reg_re_q) tx_d = bus.reg_rdata;
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            rx_d     = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              bitcnt_d = '0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                end
              end else if (state_q == PTR) begin
                state_d    = PTR_ACK;
                reg_addr_d = rx_byte;
              end else begin
                state_d     = WDATA_ACK;
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
              end
            end
          end
        end
        // The fall after the 8th bit starts our ACK; the 9th rise ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise) begin
            bitcnt_d = '0;
            if (state_q != ADDR_ACK) begin
              state_d = WDATA;
            end else if (rw_q) begin
              state_d  = RDATA;
              reg_re_d = 1'b1;
            end else begin
              state_d = PTR;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end else if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              state_d  = RDATA_ACK;
              bitcnt_d = '0;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              state_d    = RDATA;
              bitcnt_d   = '0;
              reg_addr_d = reg_addr_q + 8'd1;
              reg_re_d   = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: begin
          if (scl_fall) sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// tb_i2c_target: bit-banged I2C controller plus register-file model around i2c_target.
// Expected results come from the I2C transaction rules: pointer load, +1 per byte modulo 256.
module tb_i2c_target;
  localparam int unsigned Q = 6;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_scl, ctl_sda;
  logic [7:0]  mem [256];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t         wr_log[$];
  int unsigned re_cnt = 0;
  int unsigned oe_cnt = 0;
  logic [7:0]  tx_bytes[$];
  logic [7:0]  rd_got[$];

  always #5 clk = ~clk;

  i2c_target_if bus ();

  i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.scl_i     = ctl_scl;
  assign bus.sda_i     = ctl_sda & ~bus.sda_oe;
  assign bus.reg_rdata = mem[bus.reg_addr];

  always @(negedge clk) begin
    if (bus.reg_we === 1'b1) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re === 1'b1) re_cnt++;
    if (bus.sda_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!ctl_scl) begin
      tick(Q); ctl_sda = 1'b1; tick(Q); ctl_scl = 1'b1; tick(2*Q);
    end else begin
      tick(Q);
    end
    ctl_sda = 1'b0; tick(2*Q); ctl_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); ctl_sda = 1'b0; tick(Q); ctl_scl = 1'b1; tick(2*Q); ctl_sda = 1'b1; tick(4*Q);
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic sampled);
    tick(Q); ctl_sda = b; tick(Q); ctl_scl = 1'b1; tick(Q);
    sampled = bus.sda_i;
    if (glitch) begin
      ctl_sda = 1'b0; tick(1); ctl_sda = b; tick(Q-1);
    end else begin
      tick(Q);
    end
    ctl_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit), s);
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(nack, 1'b0, s);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input bit glitch_last,
                           output int unsigned acks, output logic busy_mid);
    logic a;
    acks = 0;
    i2c_start();
    write_byte(8'hA0, -1, a); if (a) acks++;
    busy_mid = bus.busy;
    write_byte(ptr, -1, a); if (a) acks++;
    foreach (tx_bytes[k]) begin
      write_byte(tx_bytes[k], (glitch_last && k == tx_bytes.size() - 1) ? 3 : -1, a);
      if (a) acks++;
    end
    i2c_stop();
  endtask

  task automatic read_txn(input logic [7:0] ptr, input int unsigned n,
                          output int unsigned acks, output logic oe_nack, output logic busy_mid);
    logic a;
    logic [7:0] d;
    acks = 0;
    rd_got.delete();
    i2c_start();
    write_byte(8'hA0, -1, a); if (a) acks++;
    write_byte(ptr, -1, a); if (a) acks++;
    i2c_start();
    write_byte(8'hA1, -1, a); if (a) acks++;
    busy_mid = bus.busy;
    for (int unsigned k = 0; k < n; k++) begin
      read_byte((k == n - 1), d);
      rd_got.push_back(d);
    end
    tick(Q/2);
    oe_nack = bus.sda_oe;
    i2c_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; ctl_scl = 1'b1; ctl_sda = 1'b1;
    tick(4);
    n_cmp++;
    if ({bus.sda_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oe=%b addr=%h wdata=%h we=%b re=%b busy=%b, want all 0",
               bus.sda_oe, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy);
    end
    rst = 1'b0;
    tick(4);
    n_cmp++;
    if ({bus.sda_oe, bus.reg_addr, bus.busy} !== 10'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got oe=%b addr=%h busy=%b, want 0/00/0", bus.sda_oe, bus.reg_addr, bus.busy);
    end
  endtask

  task automatic test_write();
    int unsigned acks, base, n;
    logic bm;
    logic [7:0] ptr, ea;
    for (int unsigned it = 0; it < 4; it++) begin
      tx_bytes.delete();
      if (it == 0) begin
        ptr = 8'h10; tx_bytes.push_back(8'h5A); tx_bytes.push_back(8'hC3);
      end else begin
        ptr = 8'($urandom_range(0, 255));
        n = $urandom_range(1, 4);
        for (int unsigned k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
      end
      n = tx_bytes.size();
      base = wr_log.size();
      write_txn(ptr, 1'b0, acks, bm);
      n_cmp++;
      if (acks !== n + 2) begin n_fail++; $display("FAIL write_acks[%0d]: got %0d want %0d", it, acks, n + 2); end
      n_cmp++;
      if (bm !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid[%0d]: got %b want 1", it, bm); end
      n_cmp++;
      if (wr_log.size() - base !== n) begin
        n_fail++; $display("FAIL write_count[%0d]: got %0d want %0d", it, wr_log.size() - base, n);
      end else begin
        for (int unsigned k = 0; k < n; k++) begin
          ea = ptr + 8'(k);
          n_cmp++;
          if (wr_log[base+k] !== {ea, tx_bytes[k]}) begin
            n_fail++;
            $display("FAIL write_data[%0d.%0d]: got %h/%h want %h/%h", it, k,
                     wr_log[base+k].a, wr_log[base+k].d, ea, tx_bytes[k]);
          end
        end
      end
      ea = ptr + 8'(n);
      n_cmp++;
      if (bus.reg_addr !== ea) begin n_fail++; $display("FAIL write_ptr_end[%0d]: got %h want %h", it, bus.reg_addr, ea); end
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end[%0d]: got %b want 0", it, bus.busy); end
    end
  endtask

  task automatic test_read();
    int unsigned acks, base_re, n;
    logic oe_n, bm;
    logic [7:0] ptr, ea;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'h7E;
    for (int unsigned it = 0; it < 4; it++) begin
      if (it == 0) begin ptr = 8'h20; n = 2; end
      else if (it == 1) begin ptr = 8'hFE; n = 3; end
      else begin ptr = 8'($urandom_range(0, 255)); n = $urandom_range(1, 3); end
      base_re = re_cnt;
      read_txn(ptr, n, acks, oe_n, bm);
      n_cmp++;
      if (acks !== 3) begin n_fail++; $display("FAIL read_acks[%0d]: got %0d want 3", it, acks); end
      n_cmp++;
      if (bm !== 1'b1) begin n_fail++; $display("FAIL read_busy_mid[%0d]: got %b want 1", it, bm); end
      for (int unsigned k = 0; k < n; k++) begin
        ea = ptr + 8'(k);
        n_cmp++;
        if (rd_got[k] !== mem[ea]) begin
          n_fail++; $display("FAIL read_data[%0d.%0d]: got %h want %h", it, k, rd_got[k], mem[ea]);
        end
      end
      n_cmp++;
      if (re_cnt - base_re !== n) begin n_fail++; $display("FAIL read_re_count[%0d]: got %0d want %0d", it, re_cnt - base_re, n); end
      ea = ptr + 8'(n - 1);
      n_cmp++;
      if (bus.reg_addr !== ea) begin n_fail++; $display("FAIL read_ptr_end[%0d]: got %h want %h", it, bus.reg_addr, ea); end
      n_cmp++;
      if (oe_n !== 1'b0) begin n_fail++; $display("FAIL read_oe_after_nack[%0d]: got %b want 0", it, oe_n); end
    end
  endtask

  task automatic test_mismatch();
    int unsigned base_wr, base_re, base_oe;
    logic a0, a1, bm;
    logic [6:0] addr;
    logic rw;
    for (int unsigned it = 0; it < 3; it++) begin
      if (it == 0) begin addr = 7'h51; rw = 1'b0; end
      else begin
        addr = 7'($urandom_range(0, 127));
        if (addr == 7'h50) addr = 7'h2A;
        rw = 1'($urandom_range(0, 1));
      end
      base_wr = wr_log.size(); base_re = re_cnt; base_oe = oe_cnt;
      i2c_start();
      write_byte({addr, rw}, -1, a0);
      bm = bus.busy;
      write_byte(8'h00, -1, a1);
      i2c_stop();
      n_cmp++;
      if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL mismatch_ack[%0d]: got %b%b want 00", it, a0, a1); end
      n_cmp++;
      if (oe_cnt !== base_oe) begin n_fail++; $display("FAIL mismatch_oe[%0d]: got %0d oe cycles want 0", it, oe_cnt - base_oe); end
      n_cmp++;
      if ((wr_log.size() - base_wr) + (re_cnt - base_re) !== 0) begin
        n_fail++; $display("FAIL mismatch_strobes[%0d]: got %0d strobes want 0", it, (wr_log.size() - base_wr) + (re_cnt - base_re));
      end
      n_cmp++;
      if (bm !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy[%0d]: got %b want 0", it, bm); end
    end
  endtask

  task automatic test_wrap();
    int unsigned acks, base;
    logic bm;
    tx_bytes.delete();
    tx_bytes.push_back(8'h11);
    tx_bytes.push_back(8'h22);
    base = wr_log.size();
    write_txn(8'hFF, 1'b0, acks, bm);
    n_cmp++;
    if (wr_log.size() - base !== 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 2", wr_log.size() - base);
    end else begin
      n_cmp++;
      if (wr_log[base] !== {8'hFF, 8'h11}) begin n_fail++; $display("FAIL wrap_first: got %h want ff11", wr_log[base]); end
      n_cmp++;
      if (wr_log[base+1] !== {8'h00, 8'h22}) begin n_fail++; $display("FAIL wrap_second: got %h want 0022", wr_log[base+1]); end
    end
    n_cmp++;
    if (bus.reg_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr_end: got %h want 01", bus.reg_addr); end
  endtask

  task automatic test_reset_mid();
    int unsigned acks, base;
    logic a, s, bm;
    logic [7:0] ptr, ea;
    mem[8'h40] = 8'h00;
    i2c_start();
    write_byte(8'hA0, -1, a);
    write_byte(8'h40, -1, a);
    i2c_start();
    write_byte(8'hA1, -1, a);
    repeat (3) clock_bit(1'b1, 1'b0, s);
    tick(Q); ctl_sda = 1'b1; tick(Q); ctl_scl = 1'b1; tick(Q);
    n_cmp++;
    if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_oe: got %b want 1", bus.sda_oe); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.sda_oe, bus.busy, bus.reg_addr} !== 10'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got oe=%b busy=%b addr=%h want 0/0/00", bus.sda_oe, bus.busy, bus.reg_addr);
    end
    tick(3);
    rst = 1'b0;
    tick(4);
    ptr = 8'($urandom_range(0, 255));
    tx_bytes.delete();
    tx_bytes.push_back(8'($urandom));
    tx_bytes.push_back(8'($urandom));
    base = wr_log.size();
    write_txn(ptr, 1'b0, acks, bm);
    n_cmp++;
    if (acks !== 4) begin n_fail++; $display("FAIL rstmid_acks: got %0d want 4", acks); end
    n_cmp++;
    if (wr_log.size() - base !== 2) begin
      n_fail++; $display("FAIL rstmid_count: got %0d want 2", wr_log.size() - base);
    end else begin
      ea = ptr + 8'd1;
      n_cmp++;
      if (wr_log[base+1] !== {ea, tx_bytes[1]}) begin
        n_fail++; $display("FAIL rstmid_data: got %h want %h%h", wr_log[base+1], ea, tx_bytes[1]);
      end
    end
    ea = ptr + 8'd2;
    n_cmp++;
    if (bus.reg_addr !== ea) begin n_fail++; $display("FAIL rstmid_ptr_end: got %h want %h", bus.reg_addr, ea); end
  endtask

  task automatic test_glitch();
    int unsigned acks, base, exp_acks, exp_wr;
    logic bm;
    logic [7:0] ptr, exp_ptr;
    ptr = 8'($urandom_range(0, 255));
    tx_bytes.delete();
    tx_bytes.push_back(8'hFF);
    base = wr_log.size();
    write_txn(ptr, 1'b1, acks, bm);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_acks = 3; exp_wr = 1; exp_ptr = ptr + 8'd1;
`else
    exp_acks = 2; exp_wr = 0; exp_ptr = ptr;
`endif
    n_cmp++;
    if (acks !== exp_acks) begin n_fail++; $display("FAIL glitch_acks: got %0d want %0d", acks, exp_acks); end
    n_cmp++;
    if (wr_log.size() - base !== exp_wr) begin
      n_fail++; $display("FAIL glitch_writes: got %0d want %0d", wr_log.size() - base, exp_wr);
    end
    n_cmp++;
    if (bus.reg_addr !== exp_ptr) begin n_fail++; $display("FAIL glitch_ptr: got %h want %h", bus.reg_addr, exp_ptr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
